// File: rtl/eth_axis_tx_serializer.sv
// Serializes 32-bit AXI-Stream words into an 8-bit AXI-Stream byte stream,
// with per-frame error propagation and an optional inter-frame gap.
module eth_axis_tx_serializer #(
    parameter int unsigned IFG_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s_axis_tdata,
    input  logic [1:0]  s_axis_byte_count,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic        busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam bit         GAP_EN   = (IFG_CYCLES > 0);
    localparam logic [7:0] GAP_LOAD = GAP_EN ? 8'(IFG_CYCLES - 1) : 8'd0;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [31:0] word;
    logic [1:0]  idx;
    logic [1:0]  idx_n;
    logic [1:0]  last_idx;
    logic        last_q;
    logic        err_flag;
    logic        err_base;
    logic        ready_en;
    logic [7:0]  gap_cnt;
    logic        m_hs;
    logic        fin_hs;
    logic        s_hs;
    logic        first_last;
    logic        next_last;

    // Handshake decode; ready_en keeps tready low until the first edge after reset.
    always_comb begin
        m_hs          = m_axis_tvalid & m_axis_tready;
        fin_hs        = (state == SEND) & m_hs & (idx == last_idx);
        s_axis_tready = ready_en & ((state == IDLE) | (fin_hs & (~last_q | ~GAP_EN)));
        s_hs          = s_axis_tvalid & s_axis_tready;
        idx_n         = idx + 2'd1;
        first_last    = s_axis_tlast & (s_axis_byte_count == 2'd0);
        next_last     = last_q & (idx_n == last_idx);
        // A frame closing on this edge must not leak its error into the next frame.
        err_base      = (fin_hs & last_q) ? 1'b0 : err_flag;
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (s_hs) state_n = SEND;
            SEND: begin
                if (fin_hs) begin
                    if (s_hs)                state_n = SEND;
                    else if (last_q && GAP_EN) state_n = GAP;
                    else                     state_n = IDLE;
                end
            end
            GAP:     if (gap_cnt == 8'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Word holding register, byte lane sequencing and registered byte outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_en      <= 1'b0;
            word          <= 32'd0;
            last_q        <= 1'b0;
            last_idx      <= 2'd0;
            idx           <= 2'd0;
            err_flag      <= 1'b0;
            gap_cnt       <= 8'd0;
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (s_hs) begin
                word          <= s_axis_tdata;
                last_q        <= s_axis_tlast;
                last_idx      <= s_axis_tlast ? s_axis_byte_count : 2'd3;
                idx           <= 2'd0;
                err_flag      <= err_base | s_axis_tuser;
                m_axis_tdata  <= s_axis_tdata[7:0];
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= first_last;
                m_axis_tuser  <= first_last & (err_base | s_axis_tuser);
            end else if (m_hs) begin
                if (idx == last_idx) begin
                    idx           <= 2'd0;
                    m_axis_tdata  <= 8'd0;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tuser  <= 1'b0;
                    if (last_q) err_flag <= 1'b0;
                end else begin
                    idx          <= idx_n;
                    m_axis_tdata <= word[{idx_n, 3'b000} +: 8];
                    m_axis_tlast <= next_last;
                    m_axis_tuser <= next_last & err_flag;
                end
            end
            if (state_n == GAP && state != GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_axis_tx_serializer.sv
// Randomized self-checking bench: a word-to-byte queue model for the IFG=0
// instance and a directed inter-frame-gap check on an IFG=12 instance.
module tb_eth_axis_tx_serializer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] d0_s_data;
    logic [1:0]  d0_s_bc;
    logic        d0_s_valid, d0_s_last, d0_s_user, d0_s_ready;
    logic [7:0]  d0_m_data;
    logic        d0_m_valid, d0_m_last, d0_m_user, d0_m_ready, d0_busy;

    logic [31:0] d1_s_data;
    logic [1:0]  d1_s_bc;
    logic        d1_s_valid, d1_s_last, d1_s_user, d1_s_ready;
    logic [7:0]  d1_m_data;
    logic        d1_m_valid, d1_m_last, d1_m_user, d1_m_ready, d1_busy;

    eth_axis_tx_serializer #(.IFG_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(d0_s_data), .s_axis_byte_count(d0_s_bc),
        .s_axis_tvalid(d0_s_valid), .s_axis_tlast(d0_s_last),
        .s_axis_tuser(d0_s_user), .s_axis_tready(d0_s_ready),
        .m_axis_tdata(d0_m_data), .m_axis_tvalid(d0_m_valid),
        .m_axis_tlast(d0_m_last), .m_axis_tuser(d0_m_user),
        .m_axis_tready(d0_m_ready), .busy_o(d0_busy)
    );

    eth_axis_tx_serializer #(.IFG_CYCLES(12)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(d1_s_data), .s_axis_byte_count(d1_s_bc),
        .s_axis_tvalid(d1_s_valid), .s_axis_tlast(d1_s_last),
        .s_axis_tuser(d1_s_user), .s_axis_tready(d1_s_ready),
        .m_axis_tdata(d1_m_data), .m_axis_tvalid(d1_m_valid),
        .m_axis_tlast(d1_m_last), .m_axis_tuser(d1_m_user),
        .m_axis_tready(d1_m_ready), .busy_o(d1_busy)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic model_err = 1'b0;
    int   rdy_mode = 0;
    int   cyc = 0;
    int   nbytes = 0;
    int   first_hs = 0;
    int   last_hs = 0;
    logic hold_p = 1'b0;
    exp_t hold_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: an accepted word expands to its byte list; the final byte of a
    // frame carries the OR of every tuser seen in that frame.
    task automatic model_word(input logic [31:0] d, input logic l, input logic [1:0] bc, input logic u);
        int   n;
        exp_t e;
        n = l ? int'(bc) + 1 : 4;
        model_err = model_err | u;
        for (int i = 0; i < n; i++) begin
            e.data = d[8*i +: 8];
            e.last = l && (i == n - 1);
            e.user = e.last ? model_err : 1'b0;
            exp_q.push_back(e);
        end
        if (l) model_err = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            hold_p = 1'b0;
        end else begin
            if (d0_s_valid && d0_s_ready) model_word(d0_s_data, d0_s_last, d0_s_bc, d0_s_user);
            if (d0_m_valid) begin
                if (hold_p) check("hold_stable", {21'd0, d0_m_data, d0_m_last, d0_m_user},
                                  {21'd0, hold_v.data, hold_v.last, hold_v.user});
                if (d0_m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_byte", 32'(d0_m_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_data", 32'(d0_m_data), 32'(e.data));
                        check("byte_last", 32'(d0_m_last), 32'(e.last));
                        check("byte_user", 32'(d0_m_user), 32'(e.user));
                    end
                    if (nbytes == 0) first_hs = cyc;
                    last_hs = cyc;
                    nbytes++;
                end
            end
            hold_p = d0_m_valid && !d0_m_ready;
            hold_v.data = d0_m_data;
            hold_v.last = d0_m_last;
            hold_v.user = d0_m_user;
        end
    end

    // Downstream ready pattern: 0 always, 1 toggle, 2 random.
    initial begin
        d0_m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       d0_m_ready = 1'b1;
                1:       d0_m_ready = ~d0_m_ready;
                default: d0_m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] bc, input logic u);
        int n;
        d0_s_data = d; d0_s_last = l; d0_s_bc = bc; d0_s_user = u; d0_s_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (d0_s_ready) break;
            n++;
            if (n > 200) begin
                check("s_ready_timeout", 32'(d0_s_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        d0_s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   nw, n, gapcnt, vcnt;
        logic gap_busy;
        rst = 1'b1;
        d0_s_data = '0; d0_s_bc = '0; d0_s_valid = 0; d0_s_last = 0; d0_s_user = 0;
        d1_s_data = '0; d1_s_bc = '0; d1_s_valid = 0; d1_s_last = 0; d1_s_user = 0;
        d1_m_ready = 1'b1;

        #22;
        check("rst_outputs", {d0_m_data, d0_m_valid, d0_m_last, d0_m_user, d0_busy}, 32'd0);
        check("rst_s_ready", {30'd0, d0_s_ready, d1_s_ready}, 32'd0);
        check("rst_busy1", {d1_m_data, d1_m_valid, d1_busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(d0_s_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {30'd0, d0_s_ready, d1_s_ready}, 32'd3);

        // Two-word frame at full rate: six bytes on six consecutive cycles.
        rdy_mode = 0;
        @(posedge clk); #1;
        nbytes = 0;
        send_word(32'h4433_2211, 1'b0, 2'd2, 1'b0);
        send_word(32'h0000_6655, 1'b1, 2'd1, 1'b0);
        drain();
        check("burst_bytes", 32'(nbytes), 32'd6);
        check("burst_span", 32'(last_hs - first_hs), 32'd5);

        // Same frame under a toggling ready.
        rdy_mode = 1;
        nbytes = 0;
        send_word(32'h4433_2211, 1'b0, 2'd0, 1'b0);
        send_word(32'h0000_6655, 1'b1, 2'd1, 1'b0);
        drain();
        check("toggle_bytes", 32'(nbytes), 32'd6);

        // Error on the first word reaches only the tlast byte; next frame is clean.
        send_word(32'h8877_6655, 1'b0, 2'd1, 1'b1);
        send_word(32'hDDCC_BBAA, 1'b1, 2'd3, 1'b0);
        send_word(32'h0033_2211, 1'b1, 2'd2, 1'b0);
        drain();

        // Randomized frames, ready patterns and source idle cycles.
        for (int f = 0; f < 40; f++) begin
            rdy_mode = $urandom_range(0, 2);
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                send_word($urandom, w == nw - 1, 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
        drain();

        // Reset in the middle of a word carrying an error flag.
        rdy_mode = 0;
        send_word(32'hDDCC_BBAA, 1'b0, 2'd0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {d0_m_data, d0_m_valid, d0_m_last, d0_m_user}, 32'd0);
        check("midrst_busy_ready", {30'd0, d0_busy, d0_s_ready}, 32'd0);
        exp_q.delete();
        model_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_word(32'h0000_00EE, 1'b1, 2'd0, 1'b0);
        drain();

        // Inter-frame gap on the IFG=12 instance, two single-word frames back to back.
        @(posedge clk); #1;
        d1_s_data = 32'hA1B2_C3D4; d1_s_last = 1'b1; d1_s_bc = 2'd3; d1_s_user = 1'b0; d1_s_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (d1_s_ready || n > 100) break;
            n++;
        end
        check("ifg_first_accept", 32'(d1_s_ready), 32'd1);
        @(posedge clk); #1;
        d1_s_data = 32'h1122_3344;
        gapcnt = 0; vcnt = 0; n = 0; gap_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (d1_s_ready) break;
            if (d1_m_valid) vcnt++;
            else begin
                gapcnt++;
                gap_busy = gap_busy & d1_busy;
            end
            n++;
            if (n > 100) begin
                check("ifg_timeout", 32'(d1_s_ready), 32'd1);
                break;
            end
        end
        check("ifg_idle_cycles", 32'(gapcnt), 32'd12);
        check("ifg_frame_bytes", 32'(vcnt), 32'd4);
        check("ifg_busy_in_gap", 32'(gap_busy), 32'd1);
        @(posedge clk); #1;
        d1_s_valid = 1'b0;
        @(negedge clk);
        check("ifg_next_byte0", {22'd0, d1_m_valid, d1_m_data, d1_m_last}, {22'd0, 1'b1, 8'h44, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
